pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, datapath/address width.
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap.
REQ-002 Ports SHALL be (name, direction, width, meaning); one clock, reset synchronous and active-high:
- clk, in, 1, sole clock.
- reset_i, in, 1, synchronous active-high reset.
- mem_req_o, out, 1, bus request.
- mem_addr_o, out, XLEN, byte address.
- mem_we_o, out, 1, bus write.
- mem_ready_i, in, 1, bus transfer complete this cycle.
- mem_rdata_i, in, XLEN, bus read data.
- next_pc_sel_i, in, 2, 00 increment, 01 relative, 10 register, 11 absolute.
- target_i, in, XLEN, decoder offset/absolute address.
- rs1_i, in, XLEN, register source 1.
- mem_access_i, in, 1, decoded instruction is load/store.
- mem_write_i, in, 1, decoded access is a store.
- d_addr_sel_i, in, 1, data address from rs1_i (1) or target_i (0).
- illegal_i, in, 1, decoder flags illegal instruction.
- halt_i, in, 1, debug halt request (level).
- step_i, in, 1, single-step pulse while halted.
- instr_o, out, XLEN, latched instruction.
- pc_o, out, XLEN, current PC.
- decode_en_o, out, 1, decoder/register-write enable.
- halted_o, out, 1, core halted.
- trap_o, out, 1, one-cycle trap pulse.
- cause_o, out, 2, 0 none, 1 illegal, 2 misaligned target.
- epc_o, out, XLEN, PC of trapping instruction.
- instret_o, out, XLEN, retired-instruction counter.

Function
REQ-003 States SHALL be FETCH, EXEC, WRITE, HALTED.
REQ-004 FETCH: mem_req_o=1, mem_we_o=0, mem_addr_o=pc; SHALL hold any number of wait cycles until mem_ready_i=1, then instr_o<=mem_rdata_i, go to EXEC.
REQ-005 EXEC: decode_en_o=1. If mem_access_i=1: mem_req_o=1, mem_we_o=mem_write_i, mem_addr_o = d_addr_sel_i ? rs1_i : target_i; SHALL hold until mem_ready_i=1. Otherwise the state completes in one cycle.
REQ-006 Next PC SHALL be computed modulo 2^XLEN as:
- 00: pc+4.
- 01: pc+target_i.
- 10: rs1_i.
- 11: target_i.
REQ-007 On EXEC completion without trap: pc<=next PC, instret_o increments (wraps), go to WRITE.
REQ-008 illegal_i=1 in EXEC SHALL trap in the first EXEC cycle without issuing a bus request. A next PC with bits[1:0]!=0 SHALL also trap, after any bus wait completes.
- On trap: epc_o<=pc, cause_o<=code (illegal has priority), pc<=TRAP_VECTOR, trap_o=1 for that cycle, instret_o unchanged, go to WRITE.
REQ-009 decode_en_o SHALL be 0 in the trap cycle and in every non-EXEC state.
REQ-010 WRITE SHALL last one cycle. Exit: go to HALTED if halt_i=1 or the step flag is set; else go to FETCH.
REQ-011 HALTED: halted_o=1, no bus request.
- step_i=1 sets the step flag and goes to FETCH; the flag clears on the next WRITE→HALTED transition.
- halt_i=0 with step_i=0 goes to FETCH.
REQ-012 step_i SHALL be ignored outside HALTED. halt_i SHALL be sampled only in WRITE, so an instruction is never abandoned mid-bus-transfer.
REQ-013 mem_addr_o SHALL equal pc whenever mem_req_o=0.
REQ-014 cause_o and epc_o SHALL hold until the next trap.

Reset
REQ-015 reset_i=1 at a clock edge SHALL force state=FETCH, pc=RESET_VECTOR, instr_o=0, instret_o=0, epc_o=0, cause_o=0, step flag=0, trap_o=0, halted_o=0. It SHALL take priority in any state, including mid-wait on the bus; the pending transfer is abandoned.
REQ-016 In the first cycle after reset, mem_req_o=1 and mem_addr_o=RESET_VECTOR.

Structure
REQ-017 The state enum, next_pc_sel codes and cause codes SHALL live in the shared package proc_pkg.
REQ-018 The next-PC/misalignment logic SHALL be one combinational sub-module, pc_next. Everything else stays in pc_sequencer.

Verification
REQ-019 Reset, zero-wait bus, sel=00 for 3 instructions -> pc_o 0,4,8,12; instret_o=3; 3 cycles per instruction.
REQ-020 Fetch with mem_ready_i low for 2 cycles, then a load with rs1_i=0x40, d_addr_sel_i=1 and 1 wait cycle -> mem_addr_o=0x40 during EXEC; instruction takes 6 cycles.
REQ-021 illegal_i=1 at pc=0x8 -> trap_o pulse, epc_o=0x8, cause_o=1, next fetch at 0x100, instret_o unchanged.
REQ-022 sel=10 with rs1_i=0x22 -> cause_o=2, pc_o=0x100.
REQ-023 halt_i=1 -> HALTED after WRITE; two step_i pulses -> exactly 2 instructions retired, halted_o returns to 1 after each.
REQ-024 reset_i asserted during an EXEC bus wait -> next cycle: FETCH at RESET_VECTOR, instret_o=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the PC sequencer slice: FSM state codes,
// next-PC select codes and trap cause codes.
package proc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_FETCH  = 2'd0;
   localparam state_t S_EXEC   = 2'd1;
   localparam state_t S_WRITE  = 2'd2;
   localparam state_t S_HALTED = 2'd3;

   localparam logic [1:0] SEL_INC = 2'b00;
   localparam logic [1:0] SEL_REL = 2'b01;
   localparam logic [1:0] SEL_REG = 2'b10;
   localparam logic [1:0] SEL_ABS = 2'b11;

   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection and misalignment detection.
// Ports: pc_i, sel_i, target_i, rs1_i in; next_pc_o, misaligned_o out.
module pc_next
   import proc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [1:0]      sel_i,
   input  logic [XLEN-1:0] target_i,
   input  logic [XLEN-1:0] rs1_i,
   output logic [XLEN-1:0] next_pc_o,
   output logic            misaligned_o
);

   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   always_comb begin
      next_pc_o = pc_i + FOUR;
      unique case (sel_i)
         SEL_INC: next_pc_o = pc_i + FOUR;
         SEL_REL: next_pc_o = pc_i + target_i;
         SEL_REG: next_pc_o = rs1_i;
         SEL_ABS: next_pc_o = target_i;
         default: next_pc_o = pc_i + FOUR;
      endcase
   end

   assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/exec/write PC sequencer with trap and debug halt/step.
// Ports: clk, reset_i; mem_* bus; decoder controls in; pc/instr/trap/instret out.
module pc_sequencer
   import proc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            reset_i,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic            mem_we_o,
   input  logic            mem_ready_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic [1:0]      next_pc_sel_i,
   input  logic [XLEN-1:0] target_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic            mem_access_i,
   input  logic            mem_write_i,
   input  logic            d_addr_sel_i,
   input  logic            illegal_i,
   input  logic            halt_i,
   input  logic            step_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            decode_en_o,
   output logic            halted_o,
   output logic            trap_o,
   output logic [1:0]      cause_o,
   output logic [XLEN-1:0] epc_o,
   output logic [XLEN-1:0] instret_o
);

   localparam logic [XLEN-1:0] ONE = XLEN'(1);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instret_q, instret_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [1:0]      cause_q, cause_d;
   logic            step_q, step_d;

   logic [XLEN-1:0] next_pc;
   logic            misaligned;

   pc_next #(
      .XLEN (XLEN)
   ) u_pc_next (
      .pc_i         (pc_q),
      .sel_i        (next_pc_sel_i),
      .target_i     (target_i),
      .rs1_i        (rs1_i),
      .next_pc_o    (next_pc),
      .misaligned_o (misaligned)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      instret_d   = instret_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      step_d      = step_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = pc_q;
      decode_en_o = 1'b0;
      trap_o      = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_req_o = 1'b1;
            if (mem_ready_i) begin
               instr_d = mem_rdata_i;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            if (illegal_i) begin
               // Illegal traps at once; the data access is never issued.
               trap_o  = 1'b1;
               epc_d   = pc_q;
               cause_d = CAUSE_ILLEGAL;
               pc_d    = TRAP_VECTOR;
               state_d = S_WRITE;
            end else begin
               decode_en_o = 1'b1;
               if (mem_access_i) begin
                  mem_req_o  = 1'b1;
                  mem_we_o   = mem_write_i;
                  mem_addr_o = d_addr_sel_i ? rs1_i : target_i;
               end
               if (!mem_access_i || mem_ready_i) begin
                  state_d = S_WRITE;
                  if (misaligned) begin
                     trap_o      = 1'b1;
                     decode_en_o = 1'b0;
                     epc_d       = pc_q;
                     cause_d     = CAUSE_MISALIGN;
                     pc_d        = TRAP_VECTOR;
                  end else begin
                     pc_d      = next_pc;
                     instret_d = instret_q + ONE;
                  end
               end
            end
         end

         S_WRITE: begin
            if (halt_i || step_q) begin
               state_d = S_HALTED;
               step_d  = 1'b0;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_HALTED: begin
            if (step_i) begin
               step_d  = 1'b1;
               state_d = S_FETCH;
            end else if (!halt_i) begin
               state_d = S_FETCH;
            end
         end

         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_VECTOR;
         instr_q   <= '0;
         instret_q <= '0;
         epc_q     <= '0;
         cause_q   <= CAUSE_NONE;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
         epc_q     <= epc_d;
         cause_q   <= cause_d;
         step_q    <= step_d;
      end
   end

   assign pc_o      = pc_q;
   assign instr_o   = instr_q;
   assign instret_o = instret_q;
   assign epc_o     = epc_q;
   assign cause_o   = cause_q;
   assign halted_o  = (state_q == S_HALTED);

endmodule
